// File: rtl/nand_lab_pkg.sv
// ============================================================================
//  Module      : nand_lab_pkg
//  Description : Shared types, constants and helpers for the NAND reduction lab.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nand_lab_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_NAND = 2'b01,
    MODE_OR   = 2'b10,
    MODE_NOR  = 2'b11
  } mode_e;

  typedef struct packed {
    logic in_inv;
    logic out_inv;
  } inv_t;

  localparam int TXN_COUNT_W = 16;

  // OR/NOR are AND/NAND with De Morgan inversion on the inputs.
  function automatic inv_t mode_decode(input mode_e m);
    logic [1:0] mb;
    inv_t       r;
    mb        = m;
    r.in_inv  = mb[1];
    r.out_inv = mb[1] ^ mb[0];
    return r;
  endfunction

  function automatic int level_nodes(input int w, input int l);
    int n;
    n = w;
    for (int k = 0; k < l; k++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int level_off(input int w, input int l);
    int s;
    s = 0;
    for (int k = 0; k < l; k++) s += level_nodes(w, k);
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nand2_and.sv
// ============================================================================
//  Module      : nand2_and
//  Description : 2-input AND built from a NAND followed by a self-NAND.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nand2_and (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  logic w_nand;

  assign w_nand = ~(a_i & b_i);
  assign y_o    = ~(w_nand & w_nand);

endmodule

`default_nettype wire

// File: rtl/nand_reduce_pipe.sv
// ============================================================================
//  Module      : nand_reduce_pipe
//  Description : Pipelined WIDTH-input AND/NAND/OR/NOR reduction made of NAND2
//                nodes, valid/ready stream with global stall.
//                Optional macro NAND_REDUCE_COUNT_EN enables txn_count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nand_reduce_pipe
  import nand_lab_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_data,
  output logic [TXN_COUNT_W-1:0] txn_count
);

  localparam int LEVELS = $clog2(WIDTH);
  // All tree levels (stage 0 .. LEVELS) packed back to back in one vector.
  localparam int TOTAL  = level_off(WIDTH, LEVELS + 1);

  logic             w_en;
  logic [TOTAL-1:0] tree_q, tree_d;
  logic [LEVELS:0]  valid_q, valid_d;
  mode_e            mode_q [LEVELS+1];
  mode_e            mode_d [LEVELS+1];
  inv_t             w_in_dec, w_out_dec;
  logic             w_last;
  logic             w_unused;

  assign w_en      = out_ready | ~out_valid;
  assign in_ready  = w_en;
  assign out_valid = valid_q[LEVELS];
  assign valid_d   = {valid_q[LEVELS-1:0], in_valid};

  assign w_in_dec  = mode_decode(mode_e'(in_mode));
  assign w_out_dec = mode_decode(mode_q[LEVELS]);
  assign w_unused  = w_in_dec.out_inv ^ w_out_dec.in_inv;

  always_comb begin
    mode_d[0] = mode_e'(in_mode);
    for (int k = 1; k <= LEVELS; k++) mode_d[k] = mode_q[k-1];
  end

  genvar b, l, j;
  for (b = 0; b < WIDTH; b++) begin : g_in
    logic w_self_nand;
    assign w_self_nand = ~(in_data[b] & in_data[b]);
    assign tree_d[b]   = w_in_dec.in_inv ? w_self_nand : in_data[b];
  end

  for (l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int NIN     = level_nodes(WIDTH, l - 1);
    localparam int NOUT    = level_nodes(WIDTH, l);
    localparam int OFF_IN  = level_off(WIDTH, l - 1);
    localparam int OFF_OUT = level_off(WIDTH, l);
    for (j = 0; j < NOUT; j++) begin : g_node
      if (2 * j + 1 < NIN) begin : g_pair
        nand2_and u_and (
          .a_i (tree_q[OFF_IN + 2*j]),
          .b_i (tree_q[OFF_IN + 2*j + 1]),
          .y_o (tree_d[OFF_OUT + j])
        );
      end else begin : g_pad
        // Odd leftover node: pad with the AND identity.
        nand2_and u_and (
          .a_i (tree_q[OFF_IN + 2*j]),
          .b_i (1'b1),
          .y_o (tree_d[OFF_OUT + j])
        );
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tree_q  <= '0;
      valid_q <= '0;
      for (int k = 0; k <= LEVELS; k++) mode_q[k] <= MODE_AND;
    end else if (w_en) begin
      tree_q  <= tree_d;
      valid_q <= valid_d;
      for (int k = 0; k <= LEVELS; k++) mode_q[k] <= mode_d[k];
    end
  end

  assign w_last   = tree_q[TOTAL-1];
  assign out_data = w_out_dec.out_inv ? ~(w_last & 1'b1) : w_last;

`ifdef NAND_REDUCE_COUNT_EN
  logic [TXN_COUNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (out_valid && out_ready && (count_q != {TXN_COUNT_W{1'b1}})) begin
      count_q <= count_q + {{(TXN_COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign txn_count = count_q;
`else
  assign txn_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nand_reduce_pipe.sv
// ============================================================================
//  Module      : tb_nand_reduce_pipe
//  Description : Directed self-checking bench for nand_reduce_pipe (WIDTH 8 and 5).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nand_reduce_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_data;
  logic [7:0]  a_in_data;
  logic [1:0]  a_in_mode;
  logic [15:0] a_txn;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_data;
  logic [4:0]  b_in_data;
  logic [1:0]  b_in_mode;
  logic [15:0] b_txn;

  int n_cmp = 0;
  int n_err = 0;
  bit rx_a[$];

`ifdef NAND_REDUCE_COUNT_EN
  localparam logic [15:0] CNT10 = 16'd10;
`else
  localparam logic [15:0] CNT10 = 16'd0;
`endif

  nand_reduce_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .txn_count(a_txn)
  );

  nand_reduce_pipe #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .txn_count(b_txn)
  );

  always @(negedge clk) if (!rst && a_out_valid && a_out_ready) rx_a.push_back(a_out_data);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic lat_check(input bit sel, input string tag, input logic [7:0] d,
                           input logic [1:0] m, input logic exp);
    logic v, o;
    if (!sel) begin a_in_valid = 1'b1; a_in_data = d;      a_in_mode = m; end
    else      begin b_in_valid = 1'b1; b_in_data = d[4:0]; b_in_mode = m; end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      v = sel ? b_out_valid : a_out_valid;
      o = sel ? b_out_data  : a_out_data;
      chk($sformatf("%s_v%0d", tag, k), {31'd0, v}, {31'd0, (k == 4)});
      if (k == 4) chk({tag, "_d"}, {31'd0, o}, {31'd0, exp});
    end
    @(posedge clk); #1;
  endtask

  logic [7:0] ms_d [4] = '{8'hFF, 8'h00, 8'h00, 8'h80};
  logic [1:0] ms_m [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
  logic       ms_e [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] bp_d [6] = '{8'hFF, 8'h7F, 8'h00, 8'h01, 8'h00, 8'hFF};
  logic [1:0] bp_m [6] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
  logic       bp_e [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  int si, sg, tg;
  bit acc;

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_data = 8'hFF; a_in_mode = 2'b00; a_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 5'h1F; b_in_mode = 2'b00; b_out_ready = 1'b1;

    // Reset held two edges with in_valid high.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ov", {31'd0, a_out_valid}, 32'd0);
    chk("rst_od", {31'd0, a_out_data}, 32'd0);
    chk("rst_cnt", {16'd0, a_txn}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    chk("rel_ir", {31'd0, a_in_ready}, 32'd1);
    chk("rel_ov", {31'd0, a_out_valid}, 32'd0);
    chk("rel_cnt", {16'd0, a_txn}, 32'd0);
    chk("rel_ir5", {31'd0, b_in_ready}, 32'd1);
    @(posedge clk); #1;

    lat_check(1'b0, "and_ff", 8'hFF, 2'b00, 1'b1);
    lat_check(1'b0, "and_fe", 8'hFE, 2'b00, 1'b0);

    // Back-to-back mode stream.
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_data = ms_d[i]; a_in_mode = ms_m[i];
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("ms_v%0d", i), {31'd0, a_out_valid}, 32'd1);
      chk($sformatf("ms_d%0d", i), {31'd0, a_out_data}, {31'd0, ms_e[i]});
    end
    @(negedge clk);
    chk("ms_tail_v", {31'd0, a_out_valid}, 32'd0);
    @(posedge clk); #1;

    // Backpressure: 5-cycle stall after the first delivery.
    rx_a.delete();
    fork
      begin
        si = 0; sg = 0;
        while (si < 6 && sg < 100) begin
          a_in_valid = 1'b1; a_in_data = bp_d[si]; a_in_mode = bp_m[si];
          @(negedge clk);
          acc = a_in_ready;
          @(posedge clk); #1;
          if (acc) si++;
          sg++;
        end
        a_in_valid = 1'b0;
        if (si < 6) chk("bp_send_timeout", 32'd0, 32'd1);
      end
      begin
        tg = 0;
        while (rx_a.size() < 1 && tg < 50) begin @(posedge clk); #1; tg++; end
        if (tg >= 50) chk("bp_first_timeout", 32'd0, 32'd1);
        a_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("bp_ir%0d", k), {31'd0, a_in_ready}, 32'd0);
          chk($sformatf("bp_ov%0d", k), {31'd0, a_out_valid}, 32'd1);
          chk($sformatf("bp_od%0d", k), {31'd0, a_out_data}, {31'd0, bp_e[1]});
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
      end
    join
    tg = 0;
    while (rx_a.size() < 6 && tg < 100) begin @(posedge clk); #1; tg++; end
    repeat (6) begin @(posedge clk); #1; end
    chk("bp_cnt", rx_a.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < rx_a.size()) chk($sformatf("bp_%0d", i), {31'd0, rx_a[i]}, {31'd0, bp_e[i]});
      else                 chk($sformatf("bp_missing_%0d", i), 32'd0, 32'd1);
    end

    // Odd width: 5 inputs, three levels.
    lat_check(1'b1, "w5_and1f", 8'h1F, 2'b00, 1'b1);
    lat_check(1'b1, "w5_and0f", 8'h0F, 2'b00, 1'b0);
    lat_check(1'b1, "w5_or00",  8'h00, 2'b10, 1'b0);

    // Counter after ten handshakes, then mid-flight reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rx_a.delete();
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'hFF; a_in_mode = 2'(i);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("cnt10", {16'd0, a_txn}, {16'd0, CNT10});
    chk("cnt_rx", rx_a.size(), 32'd10);
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = 8'hFF; a_in_mode = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("flush_ov%0d", k), {31'd0, a_out_valid}, 32'd0);
    end
    chk("flush_cnt", {16'd0, a_txn}, 32'd0);
    chk("flush_rx", rx_a.size(), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
